cordic_lane_scheduler: RTL and testbench
========================================

CORDIC_LANE_SCHEDULER -- requirements
Module: cordic_lane_scheduler

Interface
REQ-001 Parameter: CORDIC_DATA_WIDTH, 22, width of operands and results.
REQ-002 Parameter: TIMEOUT_CYCLES, 64, enabled WAIT cycles before a lane is aborted (range 2..255).
REQ-003 Port: clk  in  1  single clock; all logic on posedge clk.
REQ-004 Port: rst  in  1  reset, synchronous and active-high.
REQ-005 Port: clk_en  in  1  when low, state, counters and outputs hold (rst excepted).
REQ-006 Port: in_valid  in  1  operand triple available.
REQ-007 Port: in_ready  out  1  high only in IDLE.
REQ-008 Port: x_one, x_two, x_three  in  CORDIC_DATA_WIDTH each  lane operands from stage 1.
REQ-009 Port: cordic_start  out  1  one-cycle issue pulse to the shared CORDIC core.
REQ-010 Port: cordic_x  out  CORDIC_DATA_WIDTH  operand of the lane being issued.
REQ-011 Port: cordic_done  in  1  core result-valid pulse.
REQ-012 Port: cordic_result  in  CORDIC_DATA_WIDTH  core result, valid with cordic_done.
REQ-013 Port: result_one, result_two, result_three  out  CORDIC_DATA_WIDTH each  per-lane results.
REQ-014 Port: done  out  1  one-cycle pulse, all three lanes complete.
REQ-015 Port: timeout_err  out  1  sticky: at least one lane aborted in the current batch.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, DONE; transitions only on clk_en-high cycles.
REQ-017 IDLE: in_valid high -> latch x_one/x_two/x_three, lane index := 0, clear timeout_err, go ISSUE.
REQ-018 ISSUE: cordic_start=1 for exactly that cycle, cordic_x = latched operand[lane]; go WAIT; timeout counter := 0.
REQ-019 cordic_done sampled only in WAIT; a cordic_done in IDLE, ISSUE or DONE is ignored.
REQ-020 WAIT, cordic_done high: result[lane] := cordic_result; lane<2 -> lane+1, ISSUE; lane=2 -> DONE.
REQ-021 WAIT, no cordic_done: counter increments; reaching TIMEOUT_CYCLES -> result[lane] := 0, timeout_err := 1, advance exactly as REQ-020.
REQ-022 DONE: done=1 for one cycle; go IDLE; in_ready returns high the following cycle.
REQ-023 Latency: with core latency L (done L>=1 cycles after start), done asserts 3L+4 cycles after the accepting IDLE cycle, all clk_en high.
REQ-024 Lanes always issued in order one, two, three; never more than one outstanding core request.
REQ-025 result_* hold their values from DONE until overwritten by the next batch; unchanged while in IDLE.
REQ-026 cordic_x is zero outside ISSUE.
REQ-027 clk_en low in ISSUE extends cordic_start for the frozen cycles; the core shares clk_en and sees one start.
REQ-028 in_valid while not in IDLE is ignored (no queuing).

Reset
REQ-029 rst high at posedge: state=IDLE, lane=0, counter=0, cordic_start=0, cordic_x=0, done=0, timeout_err=0, result_*=0, latched operands=0; rst overrides clk_en.
REQ-030 rst mid-batch abandons the batch; a late cordic_done after reset is ignored per REQ-019.

Structure
REQ-031 Shared package cordic_pkg holds CORDIC_DATA_WIDTH, FSM state encoding, 2-bit lane index type.
REQ-032 Single flat module; no sub-module; lane operands/results held as 3-entry register arrays indexed by lane.

Verification
REQ-033 Core model L=4, operands 0x00001/0x00002/0x00003, result=operand+0x100 -> starts at cycles 1,6,11 after accept; done at cycle 16; results 0x00101/0x00102/0x00103; timeout_err=0.
REQ-034 Core silent for lane two, TIMEOUT_CYCLES=8 -> result_two=0, timeout_err=1, lane three still issued and captured, done pulses once.
REQ-035 clk_en low 3 cycles during WAIT of lane one (L=4) -> done delayed exactly 3 cycles; all results correct.
REQ-036 rst asserted in WAIT of lane two, cordic_done arrives next cycle -> all outputs 0, state IDLE, in_ready=1, no capture.
REQ-037 in_valid held high continuously, two different operand sets -> second set accepted only in the cycle after done; spurious cordic_done in IDLE ignored.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC lane scheduler: data width, FSM state
// encoding and the lane index type.
package cordic_pkg;

  localparam int unsigned CORDIC_DATA_WIDTH = 22;
  localparam int unsigned NUM_LANES         = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef logic [1:0] lane_t;

  localparam lane_t LAST_LANE = 2'd2;

endpackage

// File: rtl/cordic_lane_scheduler.sv
// cordic_lane_scheduler: time-multiplexes three operand lanes onto a single
// shared CORDIC core, one request outstanding at a time, with a per-lane
// watchdog that aborts a lane whose result never arrives.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   clk_en                global enable; low freezes all state (rst excepted)
//   in_valid / in_ready   operand triple handshake (ready only in IDLE)
//   x_one..x_three        lane operands
//   cordic_start/x        issue pulse and operand to the core
//   cordic_done/result    core result handshake (honoured only in WAIT)
//   result_one..three     per-lane results, held until the next batch
//   done                  one-cycle batch-complete pulse
//   timeout_err           sticky per batch: some lane was aborted
module cordic_lane_scheduler
  import cordic_pkg::*;
#(
  parameter int unsigned CORDIC_DATA_WIDTH = cordic_pkg::CORDIC_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES    = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clk_en,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CORDIC_DATA_WIDTH-1:0] x_one,
  input  logic [CORDIC_DATA_WIDTH-1:0] x_two,
  input  logic [CORDIC_DATA_WIDTH-1:0] x_three,
  output logic                         cordic_start,
  output logic [CORDIC_DATA_WIDTH-1:0] cordic_x,
  input  logic                         cordic_done,
  input  logic [CORDIC_DATA_WIDTH-1:0] cordic_result,
  output logic [CORDIC_DATA_WIDTH-1:0] result_one,
  output logic [CORDIC_DATA_WIDTH-1:0] result_two,
  output logic [CORDIC_DATA_WIDTH-1:0] result_three,
  output logic                         done,
  output logic                         timeout_err
);

  localparam int unsigned W     = CORDIC_DATA_WIDTH;
  localparam int unsigned CNT_W = 8;

  state_e          state_q, state_d;
  lane_t           lane_q, lane_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]    op_q  [NUM_LANES];
  logic [W-1:0]    op_d  [NUM_LANES];
  logic [W-1:0]    res_q [NUM_LANES];
  logic [W-1:0]    res_d [NUM_LANES];
  logic            terr_q, terr_d;
  logic            start_q, start_d;
  logic [W-1:0]    x_q, x_d;
  logic            done_q, done_d;
  logic            ready_q, ready_d;
  logic            advance;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    res_d   = res_q;
    terr_d  = terr_q;
    advance = 1'b0;
    start_d = 1'b0;
    x_d     = '0;
    done_d  = 1'b0;
    ready_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d[0] = x_one;
          op_d[1] = x_two;
          op_d[2] = x_three;
          lane_d  = '0;
          terr_d  = 1'b0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cordic_done) begin
          res_d[lane_q] = cordic_result;
          advance       = 1'b1;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // This is the TIMEOUT_CYCLES-th enabled WAIT cycle: abort the lane
          res_d[lane_q] = '0;
          terr_d        = 1'b1;
          advance       = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (advance) begin
          if (lane_q == LAST_LANE) begin
            state_d = ST_DONE;
          end else begin
            lane_d  = lane_q + lane_t'(1);
            state_d = ST_ISSUE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered, so decode them from the state being entered
    start_d = (state_d == ST_ISSUE);
    done_d  = (state_d == ST_DONE);
    ready_d = (state_d == ST_IDLE);
    if (start_d) begin
      x_d = op_d[lane_d];
    end
  end

  // State register; clk_en freezes everything except reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lane_q  <= '0;
      cnt_q   <= '0;
      op_q    <= '{default: '0};
      res_q   <= '{default: '0};
      terr_q  <= 1'b0;
      start_q <= 1'b0;
      x_q     <= '0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else if (clk_en) begin
      state_q <= state_d;
      lane_q  <= lane_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      res_q   <= res_d;
      terr_q  <= terr_d;
      start_q <= start_d;
      x_q     <= x_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign in_ready     = ready_q;
  assign cordic_start = start_q;
  assign cordic_x     = x_q;
  assign result_one   = res_q[0];
  assign result_two   = res_q[1];
  assign result_three = res_q[2];
  assign done         = done_q;
  assign timeout_err  = terr_q;

endmodule

// File: tb/tb_cordic_lane_scheduler.sv
// Scoreboard bench for cordic_lane_scheduler with a behavioural CORDIC core
// of latency 4 (result = operand + 0x100) that shares clk_en.
module tb_cordic_lane_scheduler;

  localparam int unsigned W  = 22;
  localparam int unsigned TO = 8;
  localparam int          L  = 4;

  logic         clk = 1'b0;
  logic         rst, clk_en, in_valid, in_ready;
  logic [W-1:0] x_one, x_two, x_three;
  logic         cordic_start, cordic_done;
  logic [W-1:0] cordic_x, cordic_result;
  logic [W-1:0] result_one, result_two, result_three;
  logic         done, timeout_err;

  cordic_lane_scheduler #(
    .CORDIC_DATA_WIDTH(W),
    .TIMEOUT_CYCLES   (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clk_en       (clk_en),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .x_one        (x_one),
    .x_two        (x_two),
    .x_three      (x_three),
    .cordic_start (cordic_start),
    .cordic_x     (cordic_x),
    .cordic_done  (cordic_done),
    .cordic_result(cordic_result),
    .result_one   (result_one),
    .result_two   (result_two),
    .result_three (result_three),
    .done         (done),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural core: done L enabled cycles after an enabled start
  int           core_cnt = 0;
  logic [W-1:0] core_x = '0;
  logic         silent_en = 1'b0;
  logic [W-1:0] silent_val = '0;
  logic         spur = 1'b0;
  logic [W-1:0] spur_val = '0;

  always @(posedge clk) begin
    if (clk_en) begin
      if (cordic_start) begin
        core_cnt <= L;
        core_x   <= cordic_x;
      end else if (core_cnt > 0) begin
        core_cnt <= core_cnt - 1;
      end
    end
  end

  assign cordic_done   = spur | ((core_cnt == 1) && !(silent_en && core_x == silent_val));
  assign cordic_result = spur ? spur_val : core_x + W'(22'h100);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [W-1:0] r1, r2, r3;
    logic         terr;
    int           lat;
  } exp_t;

  exp_t exp_q[$];

  // Monitor: tracks accepts/issues and checks each done against the scoreboard
  int           acc_cyc  = 0;
  int           starts   = 0;
  int           done_cnt = 0;
  int           acc_hist[$];
  int           done_hist[$];
  logic [W-1:0] cur_ops[3];

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      starts = 0;
    end else begin
      if (!cordic_start) chk("cordic_x_idle_zero", 32'(cordic_x), 32'd0);
      if (in_valid && in_ready && clk_en) begin
        acc_cyc    = cyc;
        starts     = 0;
        cur_ops[0] = x_one;
        cur_ops[1] = x_two;
        cur_ops[2] = x_three;
        acc_hist.push_back(cyc);
      end
      if (cordic_start && clk_en) begin
        if (starts < 3) chk("cordic_x_issue", 32'(cordic_x), 32'(cur_ops[starts]));
        else            chk("extra_start", 32'(starts), 32'd2);
        starts++;
      end
      if (done && clk_en) begin
        done_cnt++;
        done_hist.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("result_one",   32'(result_one),   32'(e.r1));
          chk("result_two",   32'(result_two),   32'(e.r2));
          chk("result_three", 32'(result_three), 32'(e.r3));
          chk("timeout_err",  32'(timeout_err),  32'(e.terr));
          chk("latency",      32'(cyc - acc_cyc), 32'(e.lat));
          chk("start_count",  32'(starts),       32'd3);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [W-1:0] r1, r2, r3, input logic terr, input int lat);
    exp_t e;
    e.r1 = r1; e.r2 = r2; e.r3 = r3; e.terr = terr; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input int target);
    int k = 0;
    while (done_cnt < target && k < 100) begin
      tick(1);
      k++;
    end
    chk("done_wait", 32'(done_cnt), 32'(target));
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!in_ready && k < 100) begin
      tick(1);
      k++;
    end
    chk("ready_wait", 32'(in_ready), 32'd1);
  endtask

  // One batch; optional clk_en stall starting stall_after cycles after accept
  task automatic run_batch(input logic [W-1:0] a, b, c,
                           input logic [W-1:0] r1, r2, r3, input logic terr,
                           input int lat, input int stall_after, input int stall_len);
    int base;
    wait_ready();
    base = done_cnt;
    push_exp(r1, r2, r3, terr, lat);
    x_one = a; x_two = b; x_three = c;
    in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
    if (stall_len > 0) begin
      tick(stall_after);
      clk_en = 1'b0;
      tick(stall_len);
      clk_en = 1'b1;
    end
    wait_done(base + 1);
    tick(4);
    chk("done_once", 32'(done_cnt), 32'(base + 1));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b1; clk_en = 1'b1; in_valid = 1'b0;
    x_one = '0; x_two = '0; x_three = '0;
    tick(3);

    // Reset state
    chk("rst_in_ready",     32'(in_ready),     32'd1);
    chk("rst_cordic_start", 32'(cordic_start), 32'd0);
    chk("rst_cordic_x",     32'(cordic_x),     32'd0);
    chk("rst_done",         32'(done),         32'd0);
    chk("rst_timeout_err",  32'(timeout_err),  32'd0);
    chk("rst_result_one",   32'(result_one),   32'd0);
    chk("rst_result_two",   32'(result_two),   32'd0);
    chk("rst_result_three", 32'(result_three), 32'd0);
    rst = 1'b0;
    tick(2);

    // Basic batch, L=4: done 16 cycles after accept
    run_batch(22'h00001, 22'h00002, 22'h00003,
              22'h00101, 22'h00102, 22'h00103, 1'b0, 16, 0, 0);

    // Lane two never answered: aborted after 8 WAIT cycles, lane three still runs
    silent_en  = 1'b1;
    silent_val = 22'h00222;
    run_batch(22'h00111, 22'h00222, 22'h00333,
              22'h00211, 22'h00000, 22'h00433, 1'b1, 20, 0, 0);
    silent_en = 1'b0;

    // clk_en low for 3 cycles in lane one WAIT: done 3 cycles later
    run_batch(22'h12345, 22'h0ABCD, 22'h3FFE00,
              22'h12445, 22'h0ACCD, 22'h3FFF00, 1'b0, 19, 2, 3);
    chk("stall_terr_cleared", 32'(timeout_err), 32'd0);

    // Reset in lane two WAIT; late cordic_done arrives the cycle after reset
    wait_ready();
    base = done_cnt;
    x_one = 22'h00AAA; x_two = 22'h00BBB; x_three = 22'h00CCC;
    in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
    tick(8);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(3);
    chk("abort_in_ready",     32'(in_ready),     32'd1);
    chk("abort_cordic_start", 32'(cordic_start), 32'd0);
    chk("abort_result_one",   32'(result_one),   32'd0);
    chk("abort_result_two",   32'(result_two),   32'd0);
    chk("abort_result_three", 32'(result_three), 32'd0);
    chk("abort_timeout_err",  32'(timeout_err),  32'd0);
    chk("abort_no_done",      32'(done_cnt),     32'(base));

    // in_valid held high across two operand sets
    wait_ready();
    base = done_cnt;
    push_exp(22'h00110, 22'h00120, 22'h00130, 1'b0, 16);
    push_exp(22'h05100, 22'h06100, 22'h07100, 1'b0, 16);
    x_one = 22'h00010; x_two = 22'h00020; x_three = 22'h00030;
    in_valid = 1'b1;
    tick(1);
    x_one = 22'h05000; x_two = 22'h06000; x_three = 22'h07000;
    wait_done(base + 1);
    tick(1);
    in_valid = 1'b0;
    wait_done(base + 2);
    tick(2);
    if (acc_hist.size() >= 2 && done_hist.size() >= 2)
      chk("second_accept_gap", 32'(acc_hist[$] - done_hist[done_hist.size()-2]), 32'd1);
    else
      chk("second_accept_seen", 32'(acc_hist.size()), 32'd5);

    // Spurious core done while idle must not disturb results
    spur_val = 22'h3ABCD;
    spur = 1'b1;
    tick(2);
    spur = 1'b0;
    tick(2);
    chk("spur_result_one",   32'(result_one),   32'h05100);
    chk("spur_result_two",   32'(result_two),   32'h06100);
    chk("spur_result_three", 32'(result_three), 32'h07100);
    chk("spur_in_ready",     32'(in_ready),     32'd1);

    tick(3);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("total_dones",      32'(done_cnt),     32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
